sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
//   Parametrised single-clock FIFO, next generation of the team's sync FIFO.
//   Adds arbitrary (non-power-of-two) depth, selectable standard/FWFT read mode,
//   programmable almost-full/almost-empty thresholds, occupancy count, sync flush
//   and sticky overflow/underflow flags. Used as a rate-decoupling buffer between
//   producer/consumer pipelines in one clock domain.
// PARAMETERS
//   DATA_WIDTH     8    width of each stored word
//   FIFO_DEPTH     16   number of entries, any value >= 2
//   ADDR_WIDTH     4    pointer width, must equal $clog2(FIFO_DEPTH)
//   FWFT           0    0 = standard read (1-cycle latency), 1 = first-word-fall-through
//   AFULL_THRESH   14   almost_full asserted when count >= this value (1..FIFO_DEPTH)
//   AEMPTY_THRESH  2    almost_empty asserted when count <= this value (0..FIFO_DEPTH-1)
// PORTS
//   clk           in   1              clock, all logic on rising edge
//   rst_n         in   1              asynchronous, active-low reset
//   flush         in   1              sync clear of contents, pointers, count, error flags
//   wr_en         in   1              write request
//   wr_data       in   DATA_WIDTH     write data
//   rd_en         in   1              read request (FWFT: pop/acknowledge of head word)
//   rd_data       out  DATA_WIDTH     read data
//   rd_valid      out  1              rd_data holds a newly popped word (standard mode)
//   full          out  1              count == FIFO_DEPTH
//   empty         out  1              count == 0
//   almost_full   out  1              count >= AFULL_THRESH
//   almost_empty  out  1              count <= AEMPTY_THRESH
//   count         out  ADDR_WIDTH+1   current occupancy, 0..FIFO_DEPTH
//   overflow      out  1              sticky: write attempted while full
//   underflow     out  1              sticky: read attempted while empty
// BEHAVIOUR
// - Reset: pointers/count 0; empty=1, almost_empty=1; full, almost_full, rd_valid,
//   overflow, underflow, rd_data = 0. Storage array not reset.
// - Accept rules use flag values before the edge: wr_acc = wr_en & ~full;
//   rd_acc = rd_en & ~empty. Both may be accepted in one cycle -> count unchanged.
// - Full + wr_en + rd_en: read accepted, write rejected, overflow set.
//   Empty + wr_en + rd_en: write accepted, read rejected, underflow set.
// - Pointers advance by 1 on accept; at FIFO_DEPTH-1 wrap to 0 (only on accept).
// - count, full, empty, almost_* are registered, reflect post-edge occupancy, all
//   updated on the same edge; never mutually inconsistent.
// - Standard mode (FWFT=0): on rd_acc, rd_data <= mem[rd_ptr] at that edge,
//   rd_valid=1 for exactly that following cycle; rd_data holds last value otherwise.
// - FWFT mode (FWFT=1): rd_data continuously shows head entry whenever empty=0;
//   rd_en pops it, next word visible the following cycle; rd_valid = ~empty.
//   A word written into an empty FIFO appears on rd_data one cycle after write edge.
// - flush (sync, highest priority after reset): pointers, count, overflow, underflow,
//   rd_valid cleared, flags to reset values; wr_en/rd_en in that cycle ignored.
// - overflow/underflow stay 1 until rst_n or flush.
// TESTING
//   1. Reset, write 16 words 0x00..0x0F -> full=1 at 16th edge, almost_full at 14th,
//      count=16; 17th write -> data dropped, overflow=1, count stays 16.
//   2. Standard mode: read all 16 -> rd_data 0x00..0x0F in order, each one cycle after
//      rd_en, rd_valid pulses 16 times; 17th rd_en -> underflow=1, rd_valid=0.
//   3. FIFO_DEPTH=6, ADDR_WIDTH=3: 20 interleaved write/read cycles -> pointers wrap
//      5->0, data order preserved, count never exceeds 6.
//   4. Simultaneous wr_en+rd_en at count=3 -> count stays 3; at full -> count 15,
//      overflow=1; at empty -> count 1, underflow=1.
//   5. FWFT=1: write 0xA5 into empty -> rd_data=0xA5, empty=0 next cycle with no
//      rd_en; rd_en pops -> empty=1.
//   6. Fill to 10, assert flush with wr_en=1 -> count=0, empty=1, errors cleared;
//      rst_n low mid-burst -> all outputs to reset values immediately.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard/FWFT read, thresholds, flush and sticky errors.
// Status flags are registered from next-state occupancy, so all of them move on the same edge.
module sync_fifo_flex #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = 14,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_acc, rd_acc;

  // Accept decisions use the registered flags; flush masks both requests.
  assign wr_acc = wr_en & ~full_q & ~flush;
  assign rd_acc = rd_en & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (wr_en & full_q);
      underflow_d = underflow_q | (rd_en & empty_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_CNT);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AFULL_CNT);
      aempty_q    <= (count_d <= AEMPTY_CNT);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  // FWFT presents the head entry combinationally from the array.
  assign rd_data      = (FWFT != 0) ? (empty_q ? '0 : mem[rd_ptr_q]) : rd_data_q;
  assign rd_valid     = (FWFT != 0) ? ~empty_q : rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: three instances (standard 16-deep, 6-deep, FWFT) with
// queue scoreboards popped by per-instance monitors on the falling edge.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int a_pulses = 0;

  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  logic [7:0] sb_c[$];
  logic [7:0] model_b[$];

  // Instance A: standard mode, depth 16
  logic a_flush = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_wd = 0, a_rdata;
  logic a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0] a_cnt;

  sync_fifo_flex #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4), .FWFT(0),
    .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr), .wr_data(a_wd),
    .rd_en(a_rd), .rd_data(a_rdata), .rd_valid(a_rv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf),
    .underflow(a_udf)
  );

  // Instance B: standard mode, depth 6
  logic b_flush = 0, b_wr = 0, b_rd = 0;
  logic [7:0] b_wd = 0, b_rdata;
  logic b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [3:0] b_cnt;

  sync_fifo_flex #(
    .DATA_WIDTH(8), .FIFO_DEPTH(6), .ADDR_WIDTH(3), .FWFT(0),
    .AFULL_THRESH(5), .AEMPTY_THRESH(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr), .wr_data(b_wd),
    .rd_en(b_rd), .rd_data(b_rdata), .rd_valid(b_rv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf),
    .underflow(b_udf)
  );

  // Instance C: FWFT, depth 16
  logic c_flush = 0, c_wr = 0, c_rd = 0;
  logic [7:0] c_wd = 0, c_rdata;
  logic c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
  logic [4:0] c_cnt;

  sync_fifo_flex #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4), .FWFT(1),
    .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr), .wr_data(c_wd),
    .rd_en(c_rd), .rd_data(c_rdata), .rd_valid(c_rv), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt), .overflow(c_ovf),
    .underflow(c_udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; monitors sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_rv) begin
      a_pulses++;
      vectors++;
      if (sb_a.size() == 0) begin
        errors++;
        $display("FAIL a_rd_data: unexpected rd_valid with data %0h", a_rdata);
      end else begin
        logic [7:0] e;
        e = sb_a.pop_front();
        if (a_rdata !== e) begin
          errors++;
          $display("FAIL a_rd_data: got %0h expected %0h", a_rdata, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_rv) begin
      vectors++;
      if (sb_b.size() == 0) begin
        errors++;
        $display("FAIL b_rd_data: unexpected rd_valid with data %0h", b_rdata);
      end else begin
        logic [7:0] e;
        e = sb_b.pop_front();
        if (b_rdata !== e) begin
          errors++;
          $display("FAIL b_rd_data: got %0h expected %0h", b_rdata, e);
        end
      end
    end
  end

  // FWFT: the head word is checked in the cycle it is acknowledged.
  always @(negedge clk) begin
    if (rst_n && c_rd && c_rv) begin
      vectors++;
      if (sb_c.size() == 0) begin
        errors++;
        $display("FAIL c_rd_data: unexpected pop with data %0h", c_rdata);
      end else begin
        logic [7:0] e;
        e = sb_c.pop_front();
        if (c_rdata !== e) begin
          errors++;
          $display("FAIL c_rd_data: got %0h expected %0h", c_rdata, e);
        end
      end
    end
  end

  task automatic chk_a_reset(input string tag);
    chk({tag, "_count"}, a_cnt, 0);
    chk({tag, "_empty"}, a_empty, 1);
    chk({tag, "_aempty"}, a_ae, 1);
    chk({tag, "_full"}, a_full, 0);
    chk({tag, "_afull"}, a_af, 0);
    chk({tag, "_ovf"}, a_ovf, 0);
    chk({tag, "_udf"}, a_udf, 0);
    chk({tag, "_rv"}, a_rv, 0);
    chk({tag, "_rdata"}, a_rdata, 0);
  endtask

  initial begin
    #12;
    chk_a_reset("rst");
    chk("rst_b_empty", b_empty, 1);
    chk("rst_c_rv", c_rv, 0);
    rst_n = 1'b1;
    tick();

    // Fill A with 0x00..0x0F, then one write too many
    for (int i = 0; i < 16; i++) begin
      a_wr = 1; a_wd = 8'(i);
      tick();
      chk("t1_count", a_cnt, i + 1);
      chk("t1_afull", a_af, (i + 1 >= 14) ? 1 : 0);
      chk("t1_full", a_full, (i + 1 == 16) ? 1 : 0);
    end
    a_wd = 8'hEE;
    tick();
    a_wr = 0;
    chk("t1_ovf", a_ovf, 1);
    chk("t1_count_hold", a_cnt, 16);

    // Drain A in order, then one read too many
    for (int i = 0; i < 16; i++) begin
      a_rd = 1;
      sb_a.push_back(8'(i));
      tick();
      chk("t2_count", a_cnt, 15 - i);
    end
    tick();
    a_rd = 0;
    chk("t2_udf", a_udf, 1);
    chk("t2_rv_low", a_rv, 0);
    chk("t2_pulses", a_pulses, 16);
    chk("t2_empty", a_empty, 1);

    // Flush clears sticky errors
    a_flush = 1;
    tick();
    a_flush = 0;
    chk("t4_flush_ovf", a_ovf, 0);
    chk("t4_flush_udf", a_udf, 0);

    // Simultaneous read/write at count 3, at full, at empty
    for (int i = 0; i < 3; i++) begin
      a_wr = 1; a_wd = 8'h30 + 8'(i);
      tick();
    end
    a_rd = 1; a_wd = 8'h33; sb_a.push_back(8'h30);
    tick();
    a_rd = 0;
    chk("t4_mid_count", a_cnt, 3);
    for (int i = 0; i < 13; i++) begin
      a_wd = 8'h34 + 8'(i);
      tick();
    end
    chk("t4_full", a_full, 1);
    a_rd = 1; a_wd = 8'h99; sb_a.push_back(8'h31);
    tick();
    a_wr = 0;
    chk("t4_full_count", a_cnt, 15);
    chk("t4_full_ovf", a_ovf, 1);
    for (int i = 0; i < 15; i++) begin
      sb_a.push_back(8'h32 + 8'(i));
      tick();
    end
    chk("t4_drained", a_cnt, 0);
    a_wr = 1; a_wd = 8'h55;
    tick();
    a_wr = 0; a_rd = 0;
    chk("t4_empty_count", a_cnt, 1);
    chk("t4_empty_udf", a_udf, 1);
    chk("t4_empty_rv", a_rv, 0);
    a_rd = 1; sb_a.push_back(8'h55);
    tick();
    a_rd = 0;
    tick();

    // Fill to 10 with errors still set, then flush with a write pending
    for (int i = 0; i < 10; i++) begin
      a_wr = 1; a_wd = 8'h60 + 8'(i);
      tick();
    end
    chk("t6_count10", a_cnt, 10);
    a_flush = 1; a_wd = 8'h77;
    tick();
    a_flush = 0; a_wr = 0;
    chk("t6_count", a_cnt, 0);
    chk("t6_empty", a_empty, 1);
    chk("t6_aempty", a_ae, 1);
    chk("t6_ovf", a_ovf, 0);
    chk("t6_udf", a_udf, 0);
    tick();
    chk("t6_no_write", a_cnt, 0);
    chk("t6_sb_a_drained", sb_a.size(), 0);

    // Depth 6 interleaved traffic against a queue model
    for (int k = 0; k < 20; k++) begin
      logic w, r;
      int mc;
      w = (k % 4 != 3);
      r = (k % 3 != 0);
      mc = model_b.size();
      b_wr = w; b_rd = r; b_wd = 8'h80 + 8'(k);
      if (r && mc > 0) sb_b.push_back(model_b.pop_front());
      if (w && mc < 6) model_b.push_back(b_wd);
      tick();
      chk("t3_count", b_cnt, model_b.size());
      chk("t3_bound", (b_cnt <= 6) ? 1 : 0, 1);
    end
    b_wr = 0;
    for (int k = 0; k < 8; k++) begin
      b_rd = 1;
      if (model_b.size() > 0) sb_b.push_back(model_b.pop_front());
      tick();
    end
    b_rd = 0;
    tick();
    chk("t3_empty", b_empty, 1);
    chk("t3_sb_b_drained", sb_b.size(), 0);

    // FWFT
    c_wr = 1; c_wd = 8'hA5; sb_c.push_back(8'hA5);
    tick();
    c_wr = 0;
    chk("t5_head", c_rdata, 8'hA5);
    chk("t5_empty", c_empty, 0);
    chk("t5_rv", c_rv, 1);
    tick();
    chk("t5_hold", c_rdata, 8'hA5);
    c_rd = 1;
    tick();
    c_rd = 0;
    chk("t5_pop_empty", c_empty, 1);
    chk("t5_pop_rv", c_rv, 0);
    c_wr = 1; c_wd = 8'h11; sb_c.push_back(8'h11);
    tick();
    c_wd = 8'h22; sb_c.push_back(8'h22);
    tick();
    c_wr = 0;
    chk("t5_head2", c_rdata, 8'h11);
    c_rd = 1;
    tick();
    chk("t5_next", c_rdata, 8'h22);
    tick();
    c_rd = 0;
    chk("t5_empty2", c_empty, 1);
    chk("t5_sb_c_drained", sb_c.size(), 0);

    // Async reset in the middle of a write burst that overflows A
    for (int i = 0; i < 17; i++) begin
      a_wr = 1; a_wd = 8'hC0 + 8'(i);
      tick();
    end
    chk("t6_pre_ovf", a_ovf, 1);
    chk("t6_pre_rdata", a_rdata, 8'h55);
    #3;
    rst_n = 1'b0;
    #1;
    chk_a_reset("async");
    a_wr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", a_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
